// File: rtl/bp_stream_host_router.sv
// Stream host router: decodes ingress words to per-channel targets, an in-band
// status/control address or an error counter, and merges channel responses plus
// the status word back onto one egress stream via a round-robin arbiter and a
// 2-entry output FIFO.
module bp_stream_host_router #(
    parameter int num_chan_p          = 2,
    parameter int stream_addr_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter logic [num_chan_p*stream_addr_width_p-1:0] chan_base_addr_p = {32'h20, 32'h10},
    parameter logic [stream_addr_width_p-1:0] status_addr_p = 32'h30
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       stream_v_i,
    input  logic [stream_addr_width_p-1:0]             stream_addr_i,
    input  logic [stream_data_width_p-1:0]             stream_data_i,
    output logic                                       stream_yumi_o,
    output logic                                       stream_v_o,
    output logic [stream_data_width_p-1:0]             stream_data_o,
    input  logic                                       stream_ready_i,
    output logic [num_chan_p-1:0]                      chan_v_o,
    output logic [num_chan_p*stream_data_width_p-1:0]  chan_data_o,
    input  logic [num_chan_p-1:0]                      chan_ready_i,
    input  logic [num_chan_p-1:0]                      chan_v_i,
    input  logic [num_chan_p*stream_data_width_p-1:0]  chan_data_i,
    output logic [num_chan_p-1:0]                      chan_yumi_o,
    output logic [15:0]                                err_count_o
);

    localparam int aw    = stream_addr_width_p;
    localparam int dw    = stream_data_width_p;
    localparam int src_n = num_chan_p + 1;   // channels plus the status source
    localparam int src_w = $clog2(src_n);

    logic [num_chan_p-1:0] match;
    logic [num_chan_p-1:0] hit;
    logic                  any_match;
    logic                  status_hit;
    logic                  unmapped;
    logic                  status_accept;
    logic                  unmapped_accept;

    logic                  status_pend_reg;
    logic [dw-1:0]         status_word_reg;
    logic [15:0]           err_count_reg;
    logic [src_w-1:0]      last_grant_reg;

    logic [src_n-1:0]      src_v;
    logic                  grant_v;
    logic [src_w-1:0]      grant_idx;
    logic                  status_grant;
    logic [dw-1:0]         enq_data;

    logic [dw-1:0]         fifo_mem [2];
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic [1:0]            count_reg;
    logic                  enq;
    logic                  deq;

    // Per-channel address compare, fanout of ingress data and grant strobes
    for (genvar gi = 0; gi < num_chan_p; gi++) begin : g_chan
        assign match[gi]                  = (stream_addr_i == chan_base_addr_p[gi*aw +: aw]);
        assign chan_data_o[gi*dw +: dw]   = stream_data_i;
        assign chan_yumi_o[gi]            = grant_v && (grant_idx == src_w'(gi));
    end

    // Lowest-index match wins so duplicate base addresses resolve deterministically
    always_comb begin
        logic found;
        found = 1'b0;
        hit   = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (match[i] && !found) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign any_match       = |match;
    assign status_hit      = !any_match && (stream_addr_i == status_addr_p);
    assign unmapped        = !any_match && !status_hit;
    assign chan_v_o        = {num_chan_p{stream_v_i}} & hit;
    assign status_accept   = stream_v_i && status_hit && !status_pend_reg;
    assign unmapped_accept = stream_v_i && unmapped;
    assign stream_yumi_o   = stream_v_i && ((|(hit & chan_ready_i)) ||
                                            (status_hit && !status_pend_reg) || unmapped);

    assign src_v        = {status_pend_reg, chan_v_i};
    assign status_grant = grant_v && (grant_idx == src_w'(num_chan_p));

    // Round-robin search starting just after the last granted source; no grant while
    // the FIFO is full (even if it drains this cycle) or while reset is held
    always_comb begin
        int cand;
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (reset_n_i && (count_reg < 2'd2)) begin
            for (int k = 1; k <= src_n; k++) begin
                cand = (int'(last_grant_reg) + k) % src_n;
                if (!grant_v && src_v[src_w'(cand)]) begin
                    grant_v   = 1'b1;
                    grant_idx = src_w'(cand);
                end
            end
        end
    end

    // Select the word of the granted source for enqueue
    always_comb begin
        enq_data = status_word_reg;
        for (int i = 0; i < num_chan_p; i++) begin
            if (grant_idx == src_w'(i)) begin
                enq_data = chan_data_i[i*dw +: dw];
            end
        end
    end

    assign enq = grant_v;
    assign deq = (count_reg != 2'd0) && stream_ready_i;

    // FIFO pointers, occupancy and the arbiter's last-grant memory
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            count_reg      <= 2'd0;
            last_grant_reg <= src_w'(num_chan_p);
        end else begin
            if (enq) begin
                wr_ptr_reg     <= ~wr_ptr_reg;
                last_grant_reg <= grant_idx;
            end
            if (deq) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (enq && !deq) begin
                count_reg <= count_reg + 2'd1;
            end else if (!enq && deq) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_mem[wr_ptr_reg] <= enq_data;
        end
    end

    assign stream_v_o    = (count_reg != 2'd0);
    assign stream_data_o = fifo_mem[rd_ptr_reg];

    // Status capture/pending flag and the saturating unmapped-write counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            status_pend_reg <= 1'b0;
            status_word_reg <= '0;
            err_count_reg   <= 16'd0;
        end else begin
            if (status_accept) begin
                status_pend_reg <= 1'b1;
                status_word_reg <= dw'({err_count_reg, 16'(num_chan_p)});
            end else if (status_grant) begin
                status_pend_reg <= 1'b0;
            end
            if (status_accept && stream_data_i[0]) begin
                err_count_reg <= 16'd0;
            end else if (unmapped_accept && (err_count_reg != 16'hFFFF)) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign err_count_o = err_count_reg;

endmodule

// File: tb/tb_bp_stream_host_router.sv
// Bench for bp_stream_host_router: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a queue-based model.
module tb_bp_stream_host_router;

    localparam int NC = 2;
    localparam int W  = 32;
    localparam logic [31:0] STATUS_ADDR = 32'h30;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               stream_v = 1'b0;
    logic [31:0]        stream_addr = '0;
    logic [W-1:0]       stream_data = '0;
    logic               stream_yumi;
    logic               stream_v_out;
    logic [W-1:0]       stream_data_out;
    logic               stream_ready = 1'b0;
    logic [NC-1:0]      chan_v_out;
    logic [NC*W-1:0]    chan_data_out;
    logic [NC-1:0]      chan_ready = '0;
    logic [NC-1:0]      chan_v_in = '0;
    logic [NC*W-1:0]    chan_data_in = '0;
    logic [NC-1:0]      chan_yumi;
    logic [15:0]        err_count;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] mq[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_sword = '0;
    int          m_err = 0;
    int          m_last = NC;

    bp_stream_host_router dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .stream_v_i     (stream_v),
        .stream_addr_i  (stream_addr),
        .stream_data_i  (stream_data),
        .stream_yumi_o  (stream_yumi),
        .stream_v_o     (stream_v_out),
        .stream_data_o  (stream_data_out),
        .stream_ready_i (stream_ready),
        .chan_v_o       (chan_v_out),
        .chan_data_o    (chan_data_out),
        .chan_ready_i   (chan_ready),
        .chan_v_i       (chan_v_in),
        .chan_data_i    (chan_data_in),
        .chan_yumi_o    (chan_yumi),
        .err_count_o    (err_count)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? 32'h10 : 32'h20;
    endfunction

    // Model compare: every falling edge, derive expected outputs from the rules,
    // then advance the model to the state after the next rising edge.
    always @(negedge clk) begin
        int hit;
        int g;
        int s;
        bit sh;
        bit um;
        bit ey;
        logic [NC-1:0] ecv;
        logic [NC-1:0] ecy;
        if (!reset_n) begin
            mq.delete();
            m_pend = 1'b0;
            m_err  = 0;
            m_last = NC;
        end
        hit = -1;
        for (int i = 0; i < NC; i++) begin
            if (hit < 0 && stream_addr == base_of(i)) hit = i;
        end
        sh  = (hit < 0) && (stream_addr == STATUS_ADDR);
        um  = (hit < 0) && !sh;
        ecv = '0;
        if (stream_v && hit >= 0) ecv[hit] = 1'b1;
        ey  = stream_v && ((hit >= 0 && chan_ready[hit]) || (sh && !m_pend) || um);
        g   = -1;
        if (reset_n && mq.size() < 2) begin
            for (int k = 1; k <= NC + 1; k++) begin
                s = (m_last + k) % (NC + 1);
                if (g < 0 && ((s < NC) ? chan_v_in[s] : m_pend)) g = s;
            end
        end
        ecy = '0;
        if (g >= 0 && g < NC) ecy[g] = 1'b1;

        chk("chan_v_o", chan_v_out, ecv);
        chk("chan_data_o", chan_data_out, {NC{stream_data}});
        chk("stream_yumi_o", stream_yumi, ey);
        chk("chan_yumi_o", chan_yumi, ecy);
        chk("stream_v_o", stream_v_out, (mq.size() > 0));
        if (mq.size() > 0) chk("stream_data_o", stream_data_out, mq[0]);
        chk("err_count_o", err_count, m_err);

        if (reset_n) begin
            if (mq.size() > 0 && stream_ready) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back((g < NC) ? chan_data_in[g*W +: W] : m_sword);
                m_last = g;
                if (g == NC) m_pend = 1'b0;
            end
            if (ey && sh) begin
                m_pend  = 1'b1;
                m_sword = {m_err[15:0], 16'(NC)};
                if (stream_data[0]) m_err = 0;
            end else if (ey && um) begin
                m_err = (m_err < 65535) ? m_err + 1 : 65535;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_stream_v", stream_v_out, 0);
        chk("rst_chan_yumi", chan_yumi, 0);
        chk("rst_err_count", err_count, 0);
        step();
        reset_n = 1'b1;

        // Channel 0 write, ready then not ready
        stream_v = 1'b1; stream_addr = 32'h10; stream_data = 32'hA5; chan_ready = 2'b01;
        @(negedge clk);
        chk("ch0_chan_v", chan_v_out, 2'b01);
        chk("ch0_yumi", stream_yumi, 1);
        chk("ch0_data", chan_data_out[W-1:0], 32'hA5);
        step();
        chan_ready = 2'b00;
        @(negedge clk);
        chk("ch0_stall", stream_yumi, 0);
        step();

        // Three unmapped writes
        stream_addr = 32'h44;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("unmapped_yumi", stream_yumi, 1);
            step();
        end
        stream_v = 1'b0;
        @(negedge clk);
        chk("err_three", err_count, 16'd3);
        step();

        // Status write with clear, then a second one that must stall while pending
        stream_ready = 1'b1;
        stream_v = 1'b1; stream_addr = 32'h30; stream_data = 32'h1;
        @(negedge clk);
        chk("status_accept", stream_yumi, 1);
        step();
        stream_data = 32'h0;
        @(negedge clk);
        chk("status_stall", stream_yumi, 0);
        chk("err_cleared", err_count, 0);
        step();
        @(negedge clk);
        chk("status_word_v", stream_v_out, 1);
        chk("status_word", stream_data_out, 32'h0003_0002);
        chk("status_second_accept", stream_yumi, 1);
        step();
        stream_v = 1'b0;
        repeat (4) step();

        // Both channels valid: alternate grants, continuous egress
        chan_v_in = 2'b11;
        chan_data_in = {$urandom, $urandom};
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("rr_grant", chan_yumi, (n % 2 == 0) ? 2'b01 : 2'b10);
            if (n > 0) chk("rr_stream_v", stream_v_out, 1);
            step();
            chan_data_in = {$urandom, $urandom};
        end
        chan_v_in = 2'b00;
        repeat (3) step();

        // Backpressure: exactly two buffered, then drained in grant order
        stream_ready = 1'b0;
        chan_v_in = 2'b11;
        chan_data_in = {32'h1111_1111, 32'h0000_AAAA};
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                chk("full_no_grant", chan_yumi, 0);
                chk("full_stream_v", stream_v_out, 1);
            end
            step();
        end
        stream_ready = 1'b1;
        chan_v_in = 2'b00;
        @(negedge clk);
        chk("drain_first", stream_data_out, 32'h0000_AAAA);
        step();
        @(negedge clk);
        chk("drain_second", stream_data_out, 32'h1111_1111);
        step();
        @(negedge clk);
        chk("drain_empty", stream_v_out, 0);
        step();

        // Reset with two buffered words
        stream_ready = 1'b0;
        chan_v_in = 2'b11;
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_stream_v", stream_v_out, 0);
        chk("async_rst_chan_yumi", chan_yumi, 0);
        step();
        reset_n = 1'b1;
        stream_ready = 1'b1;
        @(negedge clk);
        chk("first_after_rst", chan_yumi, 2'b01);
        step();
        chan_v_in = 2'b00;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stream_v = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: stream_addr = 32'h10;
                1: stream_addr = 32'h20;
                2: stream_addr = 32'h30;
                3: stream_addr = 32'h44;
                default: stream_addr = $urandom;
            endcase
            stream_data  = $urandom;
            chan_ready   = 2'($urandom_range(0, 3));
            chan_v_in    = 2'($urandom_range(0, 3));
            chan_data_in = {$urandom, $urandom};
            stream_ready = ($urandom_range(0, 3) != 0);
            reset_n      = ($urandom_range(0, 399) != 0);
            step();
        end
        reset_n = 1'b1;
        chan_v_in = 2'b00;

        // Saturation of the error counter
        stream_v = 1'b1; stream_addr = 32'h44;
        repeat (65540) step();
        stream_v = 1'b0;
        @(negedge clk);
        chk("err_saturated", err_count, 16'hFFFF);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
